crack_ctrl: RTL
===============

Name: crack_ctrl

Overview:
- Key-search controller that drives one arc4 decryption core over a key sequence.
- Each candidate key is run through arc4 to completion. The controller then scans the plaintext in pt_mem, where byte 0 is the length L and bytes 1..L must be printable ASCII.
- Stops on the first key that passes, or when the key space is exhausted.
- Owns the pt_mem address/write-enable mux between arc4 and its own checker. Instantiated one per core in the parallel cracker.

Parameters:
- KEY_START, 24'h000000, first key tried.
- KEY_STEP, 1, increment between candidate keys (1..255); lets N parallel crackers interleave the key space.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  start request; accepted only in a cycle where rdy=1.
- stop  in  1  abort request from a sibling cracker.
- rdy  out  1  idle/done, ready to accept en.
- key_valid  out  1  last search found a key.
- key  out  24  found key; 0 when key_valid=0.
- arc4_en  out  1  start pulse to arc4.
- arc4_rdy  in  1  arc4 ready.
- arc4_key  out  24  candidate key to arc4.
- arc4_pt_addr  in  8  arc4's pt_mem address.
- arc4_pt_wren  in  1  arc4's pt_mem write enable.
- pt_addr  out  8  muxed pt_mem address.
- pt_wren  out  1  muxed pt_mem write enable.
- pt_rddata  in  8  pt_mem read data.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE; rdy=1; key_valid=0; key=0; arc4_en=0; arc4_key=KEY_START.
  - Applies from any state, including mid-search; the arc4 core is reset separately.
- pt_mem data is available one cycle after the address is presented: address in cycle N, pt_rddata sampled in cycle N+1.
- Pt mux:
  - In IDLE, START, WAIT_BUSY, WAIT_DONE: pt_addr=arc4_pt_addr and pt_wren=arc4_pt_wren.
  - In the check states (RD_LEN, LEN_WAIT, CHK, DONE check tail): pt_addr=checker address and pt_wren=0.
  - pt_wrdata is wired arc4→pt_mem directly, outside this block.
- State machine:
  - IDLE: rdy=1.
    - en=1 → START; load cur_key=KEY_START; clear key_valid and key; rdy drops next cycle.
    - en while rdy=0 is ignored.
  - START: wait for arc4_rdy=1, then arc4_en=1 for exactly one cycle with arc4_key=cur_key → WAIT_BUSY.
  - WAIT_BUSY: wait for arc4_rdy=0 → WAIT_DONE.
  - WAIT_DONE: arc4_rdy=1 → RD_LEN.
  - RD_LEN: pt_addr=0 → LEN_WAIT.
  - LEN_WAIT: latch L=pt_rddata; idx=1.
    - L=0 → FOUND.
    - Otherwise present pt_addr=1 → CHK.
  - CHK: byte = pt_rddata (address idx).
    - If byte < 8'h20 or byte > 8'h7E → NEXT.
    - Else if idx==L → FOUND.
    - Else idx++ and present idx+1.
    - Throughput: one byte per cycle.
  - NEXT: nk = cur_key + KEY_STEP, computed in 25 bits.
    - nk > 24'hFFFFFF → DONE with key_valid=0.
    - Otherwise cur_key=nk → START.
  - FOUND: key=cur_key; key_valid=1 → DONE.
  - DONE: rdy=1; key/key_valid held. en=1 → restart exactly as from IDLE.
- stop:
  - Sampled in every state except IDLE/DONE; a registered stop_req flag is set.
  - If the flag is set, NEXT goes to DONE with key_valid=0 instead of advancing.
  - If the flag is set during START before arc4_en is issued, the controller goes to DONE immediately.
  - FOUND takes priority over stop in the same cycle.
- The arc4 run is never aborted mid-decrypt: stop waits for WAIT_DONE and the check to complete.
- L=255 checks bytes 1..255; idx is 8 bits and never wraps past L.
- Worst-case per-key check latency is L+3 cycles after arc4 finishes.

Test Plan:
- KEY_START=0, STEP=1; bench arc4 model writes valid text (L=5, "HELLO") only for key 24'h000003, else byte 1=8'h07 → key_valid=1, key=24'h000003, exactly 4 arc4_en pulses, rdy=1.
- STEP=2, START=1; valid only at key 4 → key 4 never reached; search runs until NEXT overflow (force via START=24'hFFFFFD) → after keys FFFFFD and FFFFFF, DONE with key_valid=0, key=0.
- L=0 at key 0 → found after the first arc4 run, key=0; L=255 all 8'h7E at key 0 → found, 255 CHK cycles observed; byte 255=8'h7F → rejected, next key tried.
- stop asserted mid WAIT_DONE on key 2 → arc4 completes, no further arc4_en, DONE with key_valid=0; stop in the cycle FOUND is entered → key_valid=1.
- rst_n=0 for one cycle during CHK → next cycle IDLE, rdy=1, key_valid=0, arc4_en=0, pt_addr follows arc4_pt_addr.
- Pt mux: during WAIT_DONE, pt_wren/pt_addr mirror arc4 inputs cycle-for-cycle; during CHK, pt_wren=0 even with arc4_pt_wren=1.

Source files
------------

// File: rtl/crack_ctrl.sv
// rtl/crack_ctrl.sv - key-search controller driving one arc4 core and checking its plaintext
module crack_ctrl #(
    parameter logic [23:0] KEY_START = 24'h000000,
    parameter int          KEY_STEP  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        stop,
    output logic        rdy,
    output logic        key_valid,
    output logic [23:0] key,
    output logic        arc4_en,
    input  logic        arc4_rdy,
    output logic [23:0] arc4_key,
    input  logic [7:0]  arc4_pt_addr,
    input  logic        arc4_pt_wren,
    output logic [7:0]  pt_addr,
    output logic        pt_wren,
    input  logic [7:0]  pt_rddata
);

    typedef enum logic [3:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        RD_LEN,
        LEN_WAIT,
        CHK,
        NEXT,
        FOUND,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [23:0] cur_key;
    logic [7:0]  len;
    logic [7:0]  idx;
    logic        stop_req;
    logic        chk_sel;
    logic [7:0]  chk_addr;
    logic [24:0] next_key;
    logic        printable;
    logic        accept;

    // 25-bit sum so running off the top of the key space is visible in bit 24
    assign next_key  = {1'b0, cur_key} + 25'(KEY_STEP);
    assign printable = (pt_rddata >= 8'h20) && (pt_rddata <= 8'h7E);
    assign rdy       = (state == IDLE) || (state == DONE);
    assign accept    = rdy && en;
    assign arc4_key  = cur_key;

    // The checker only ever reads pt_mem, so it never forwards a write enable
    assign pt_addr   = chk_sel ? chk_addr : arc4_pt_addr;
    assign pt_wren   = chk_sel ? 1'b0 : arc4_pt_wren;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Search datapath: current key, length/index of the check, stop flag and result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_key   <= KEY_START;
            key       <= 24'h000000;
            key_valid <= 1'b0;
            len       <= 8'h00;
            idx       <= 8'h00;
            stop_req  <= 1'b0;
        end else begin
            if (accept) begin
                cur_key   <= KEY_START;
                key       <= 24'h000000;
                key_valid <= 1'b0;
                stop_req  <= 1'b0;
            end else if (stop && !rdy) begin
                stop_req  <= 1'b1;
            end
            case (state)
                LEN_WAIT: begin
                    len <= pt_rddata;
                    idx <= 8'd1;
                end
                CHK: begin
                    if (printable && (idx != len)) begin
                        idx <= idx + 8'd1;
                    end
                end
                NEXT: begin
                    if (!stop_req && !next_key[24]) begin
                        cur_key <= next_key[23:0];
                    end
                end
                FOUND: begin
                    key       <= cur_key;
                    key_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Next-state, arc4 start pulse and checker read address
    always_comb begin
        state_nx = state;
        arc4_en  = 1'b0;
        chk_sel  = 1'b0;
        chk_addr = 8'h00;
        case (state)
            IDLE: begin
                if (en) state_nx = START;
            end
            START: begin
                if (stop_req) begin
                    state_nx = DONE;
                end else if (arc4_rdy) begin
                    arc4_en  = 1'b1;
                    state_nx = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (!arc4_rdy) state_nx = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (arc4_rdy) state_nx = RD_LEN;
            end
            RD_LEN: begin
                chk_sel  = 1'b1;
                chk_addr = 8'h00;
                state_nx = LEN_WAIT;
            end
            LEN_WAIT: begin
                chk_sel  = 1'b1;
                chk_addr = 8'h01;
                state_nx = (pt_rddata == 8'h00) ? FOUND : CHK;
            end
            CHK: begin
                chk_sel  = 1'b1;
                chk_addr = idx + 8'd1;
                if (!printable) begin
                    state_nx = NEXT;
                end else if (idx == len) begin
                    state_nx = FOUND;
                end
            end
            NEXT: begin
                chk_sel  = 1'b1;
                state_nx = (stop_req || next_key[24]) ? DONE : START;
            end
            FOUND: begin
                chk_sel  = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                if (en) state_nx = START;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
